// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Falling-edge controller for the restoring divider. Captures
//               operands on start, runs WIDTH shift/compare/subtract steps and
//               reports quotient/remainder, while streaming quotient bits to an
//               external shift register. Optional macro DIV_ZERO_CHECK_EN
//               short-circuits division by zero straight from LOAD to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             sr_load,
    output logic             sr_in
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic             w_last;

    // Partial remainder shifted left with the next dividend bit; the compare is
    // WIDTH+1 bits so the carried-out top bit is never lost.
    assign w_t       = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_t >= {1'b0, r_dsr});
    // When w_ge holds the true difference is below 2**WIDTH, so the low bits suffice.
    assign w_rem_nxt = w_ge ? (w_t[WIDTH-1:0] - r_dsr) : w_t[WIDTH-1:0];
    assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};
    assign w_last    = (r_cnt == C_LAST);

    assign busy    = (r_state == S_LOAD) || (r_state == S_ITER);
    assign done    = (r_state == S_DONE);
    assign sr_load = (r_state == S_LOAD);
    assign sr_in   = (r_state == S_ITER) && w_ge;

    // Results are written on the edge entering DONE so they are valid with the pulse.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_dvd       <= dividend;
                    r_dsr       <= divisor;
                    r_rem       <= '0;
                    r_cnt       <= '0;
                    div_by_zero <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state     <= S_ITER;
                    end
`else
                    r_state <= S_ITER;
`endif
                end
                S_ITER: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_dvd_nxt;
                    r_cnt <= r_cnt + C_ONE;
                    if (w_last) begin
                        quotient    <= w_dvd_nxt;
                        remainder   <= w_rem_nxt;
                        div_by_zero <= (r_dsr == '0);
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// Testbench for div_sequencer: random and directed divisions driven into a
// scoreboard, checked by an independent monitor against plain / and %.
module tb_div_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero, sr_load, sr_in;
    logic [W-1:0] quotient, remainder;

    div_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .sr_load(sr_load), .sr_in(sr_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           done_edge;
        bit           iter;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   negcnt   = 0;

    always @(negedge clk) negcnt <= negcnt + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic with the documented divide-by-zero result.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int start_edge);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            e.done_edge = start_edge + 1;
            e.iter      = 1'b0;
`else
            e.done_edge = start_edge + W + 1;
            e.iter      = 1'b1;
`endif
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
            e.done_edge = start_edge + W + 1;
            e.iter      = 1'b1;
        end
        return e;
    endfunction

    // Monitor: collects the sr_in stream and sr_load count, pops on done.
    logic [W-1:0] stream = '0;
    int           itcnt  = 0;
    int           ldcnt  = 0;
    logic         done_prev = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            stream    = '0;
            itcnt     = 0;
            ldcnt     = 0;
            done_prev = 1'b0;
        end else begin
            if (sr_load) ldcnt++;
            if (busy && !sr_load) begin
                stream = {stream[W-2:0], sr_in};
                itcnt++;
            end
            if (!busy) check("sr_in_outside_iter", {31'd0, sr_in}, '0);
            if (done) begin
                exp_t e;
                check("done_single_cycle", {31'd0, done_prev}, '0);
                check("busy_in_done", {31'd0, busy}, '0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    check("latency_edge", W'(negcnt), W'(e.done_edge));
                    check("sr_load_cycles", W'(ldcnt), 32'd1);
                    check("iter_cycles", W'(itcnt), e.iter ? W'(W) : '0);
                    if (e.iter) check("sr_in_stream", stream, e.q);
                end
                stream = '0;
                itcnt  = 0;
                ldcnt  = 0;
            end
            done_prev = done;
        end
    end

    // Drives one operation; optionally pulses a stray start while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit stray, input bit expect_it);
        int k;
        @(posedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (expect_it) sb.push_back(model(a, b, negcnt + 1));
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        dividend = $urandom;
        divisor  = $urandom;
        if (stray) begin
            repeat (4) @(posedge clk);
            dividend = 32'd999;
            divisor  = 32'd3;
            start    = 1'b1;
            repeat (2) @(posedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < W + 16) begin
            @(posedge clk);
            k++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, '0);
        check("reset_done", {31'd0, done}, '0);
        check("reset_quotient", quotient, '0);
        check("reset_remainder", remainder, '0);
        check("reset_dbz", {31'd0, div_by_zero}, '0);
        check("reset_sr_load", {31'd0, sr_load}, '0);
        @(posedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        check("idle_no_start", {31'd0, busy}, '0);

        run_op(32'd100, 32'd7, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        run_op(32'd5, 32'd10, 1'b0, 1'b1);
        run_op(32'd1234, 32'd0, 1'b0, 1'b1);
        run_op(32'd100, 32'd7, 1'b1, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0001, 1'b0, 1'b1);

        // Abort at iteration 10: start, LOAD, then ten ITER edges.
        @(posedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, '0);
        check("abort_done", {31'd0, done}, '0);
        check("abort_quotient", quotient, '0);
        check("abort_remainder", remainder, '0);
        check("abort_sr_in", {31'd0, sr_in}, '0);
        repeat (2) @(posedge clk);
        reset = 1'b0;
        repeat (W + 6) @(posedge clk);
        run_op(32'd100, 32'd7, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = W'($urandom_range(1, 255));
                1: b = (i % 6 == 0) ? '0 : W'($urandom_range(1, 65535));
                2: b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op(a, b, (i % 8 == 3), 1'b1);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
